// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder
// Turns the byte stream coming out of spi_slave into register-access frames.
// A header byte selects write (bit7=1) or read (bit7=0) and carries a 7-bit
// address. A write header is followed by DATA_BYTES data bytes, MSB first,
// and produces one reg_we strobe. A read header produces one reg_re strobe,
// and the returned word is then presented MSB first on send_byte, advancing
// one byte per dummy byte received. Raising csn mid-frame discards the frame
// and pulses frame_err.
module spi_frame_decoder #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csn,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [6:0]              reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic [7:0]              send_byte,
  output logic                    frame_err,
  output logic [7:0]              frame_count
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BYTES - 1);

  // RD_WAIT is the cycle reg_re is high; RD_CAP is the following cycle, in
  // which the register file presents reg_rdata and it is captured.
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_WAIT,
    RD_CAP,
    RD
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [W-1:0]  shift;
  logic          rd_pending;

  logic [W-1:0]  shift_wr;
  logic [W-1:0]  shift_shl;
  logic [W-1:0]  rdata_shl;
  logic          abort;

  // Shifted views of the data path and the abort condition (csn high with no
  // byte arriving while a frame is open).
  always_comb begin
    shift_wr  = (shift << 8) | W'(byte_in);
    shift_shl = shift << 8;
    rdata_shl = reg_rdata << 8;
    abort     = csn && !byte_valid && (state != IDLE);
  end

  // Frame sequencer: header decode, write assembly, read capture/serialise,
  // and abort handling, with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      shift       <= '0;
      rd_pending  <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      send_byte   <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        byte_cnt   <= '0;
        send_byte  <= '0;
        rd_pending <= 1'b0;
        frame_err  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (byte_valid) begin
              reg_addr <= byte_in[6:0];
              byte_cnt <= '0;
              if (byte_in[7]) begin
                state <= WR;
              end else begin
                reg_re     <= 1'b1;
                rd_pending <= 1'b0;
                state      <= RD_WAIT;
              end
            end
          end
          WR: begin
            if (byte_valid) begin
              shift <= shift_wr;
              if (byte_cnt == LAST_IDX) begin
                reg_wdata   <= shift_wr;
                reg_we      <= 1'b1;
                frame_count <= frame_count + 8'd1;
                byte_cnt    <= '0;
                state       <= IDLE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          RD_WAIT: begin
            if (byte_valid) begin
              rd_pending <= 1'b1;
            end
            state <= RD_CAP;
          end
          RD_CAP: begin
            rd_pending <= 1'b0;
            if (!(rd_pending || byte_valid)) begin
              shift     <= reg_rdata;
              send_byte <= reg_rdata[W-1 -: 8];
              byte_cnt  <= '0;
              state     <= RD;
            end else if (DATA_BYTES == 1) begin
              send_byte <= '0;
              byte_cnt  <= '0;
              state     <= IDLE;
            end else begin
              shift     <= rdata_shl;
              send_byte <= rdata_shl[W-1 -: 8];
              byte_cnt  <= CW'(1);
              state     <= RD;
            end
          end
          RD: begin
            if (byte_valid) begin
              if (byte_cnt == LAST_IDX) begin
                send_byte <= '0;
                byte_cnt  <= '0;
                state     <= IDLE;
              end else begin
                shift     <= shift_shl;
                send_byte <= shift_shl[W-1 -: 8];
                byte_cnt  <= byte_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
